// File: rtl/p_cal_scheduler.sv
// Frame sequencer that time-multiplexes one pipelined power unit across NCH channels.
// Issues one operand set per cycle, tags results with their channel via a FIFO, and flags frame completion.
module p_cal_scheduler #(
   parameter int NCH       = 4,
   parameter int CH_W      = 2,
   parameter int TAG_DEPTH = 32,
   parameter int WIDTH     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sta,
   input  logic [NCH-1:0]   ch_mask,
   output logic [CH_W-1:0]  ch_sel,
   output logic             pcal_sta,
   input  logic             pcal_done,
   input  logic [WIDTH-1:0] pcal_p,
   output logic [WIDTH-1:0] p_out,
   output logic [CH_W-1:0]  p_ch,
   output logic             p_valid,
   output logic             busy,
   output logic             done_sig,
   output logic             overrun
);

   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [NCH-1:0]   pending_q, pending_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CH_W-1:0]  ch_sel_q;
   logic             pcal_sta_q;
   logic [WIDTH-1:0] p_out_q;
   logic [CH_W-1:0]  p_ch_q;
   logic             p_valid_q;
   logic             busy_q;
   logic             done_q, done_d;
   logic             overrun_q;

   logic [CH_W-1:0]  tag_mem [TAG_DEPTH];

   logic [NCH-1:0]   cand;
   logic [CH_W-1:0]  idx;
   logic             found;
   logic             push;
   logic             pop;

   // The first channel issues on the same edge that samples sta, so IDLE selects from ch_mask directly.
   always_comb begin
      cand  = (state_q == IDLE) ? ch_mask : pending_q;
      found = 1'b0;
      idx   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (cand[i]) begin
            found = 1'b1;
            idx   = CH_W'(i);
         end
      end
   end

   assign push = (((state_q == IDLE) && sta) || (state_q == ISSUE)) && found &&
                 (count_q != CNT_W'(TAG_DEPTH));
   assign pop  = pcal_done && (count_q != '0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
         IDLE: begin
            if (sta) begin
               pending_d = ch_mask;
               if (push) pending_d[idx] = 1'b0;
               state_d = (pending_d != '0) ? ISSUE : DRAIN;
            end
         end
         ISSUE: begin
            if (push) pending_d[idx] = 1'b0;
            state_d = (pending_d != '0) ? ISSUE : DRAIN;
         end
         DRAIN: begin
            // Stay one extra cycle so busy covers the done_sig cycle and sta is not yet accepted.
            if (done_q)              state_d = IDLE;
            else if (count_q == '0)  done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ch_sel_q   <= '0;
         pcal_sta_q <= 1'b0;
         p_out_q    <= '0;
         p_ch_q     <= '0;
         p_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
         pcal_sta_q <= push;
         p_valid_q  <= pop;
         busy_q     <= (state_d != IDLE);
         done_q     <= done_d;
         if (push) begin
            ch_sel_q <= idx;
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            p_out_q  <= pcal_p;
            p_ch_q   <= tag_mem[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (pcal_done && (count_q == '0)) overrun_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= idx;
   end

   assign ch_sel   = ch_sel_q;
   assign pcal_sta = pcal_sta_q;
   assign p_out    = p_out_q;
   assign p_ch     = p_ch_q;
   assign p_valid  = p_valid_q;
   assign busy     = busy_q;
   assign done_sig = done_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_p_cal_scheduler.sv
// Scoreboard bench for p_cal_scheduler with a fixed-latency power-unit model returning ch+1.0.
// Expected issues and results are queued at frame start and retired as the DUT strobes.
module tb_p_cal_scheduler;

   localparam int NCH = 4;
   localparam int CH_W = 2;
   localparam int TAG_DEPTH = 32;
   localparam int WIDTH = 32;
   localparam int L = 19;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sta = 1'b0;
   logic [NCH-1:0]   ch_mask = '0;
   logic [CH_W-1:0]  ch_sel;
   logic             pcal_sta;
   logic             pcal_done;
   logic [WIDTH-1:0] pcal_p;
   logic [WIDTH-1:0] p_out;
   logic [CH_W-1:0]  p_ch;
   logic             p_valid;
   logic             busy;
   logic             done_sig;
   logic             overrun;

   p_cal_scheduler #(.NCH(NCH), .CH_W(CH_W), .TAG_DEPTH(TAG_DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .sta(sta), .ch_mask(ch_mask), .ch_sel(ch_sel),
      .pcal_sta(pcal_sta), .pcal_done(pcal_done), .pcal_p(pcal_p), .p_out(p_out),
      .p_ch(p_ch), .p_valid(p_valid), .busy(busy), .done_sig(done_sig), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fval(input int v);
      case (v)
         1: fval = 32'h3F80_0000;
         2: fval = 32'h4000_0000;
         3: fval = 32'h4040_0000;
         4: fval = 32'h4080_0000;
         default: fval = 32'h0000_0000;
      endcase
   endfunction

   // Power-unit model: in-order, latency L, shares rst
   logic [L-1:0]    vld;
   logic [CH_W-1:0] chp [L];
   logic            spur = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld    <= {vld[L-2:0], pcal_sta};
         chp[0] <= ch_sel;
         for (int i = 1; i < L; i++) chp[i] <= chp[i-1];
      end
   end

   assign pcal_done = vld[L-1] | spur;
   assign pcal_p    = fval(int'(chp[L-1]) + 1);

   typedef struct {
      int          cyc;
      int          ch;
      logic [31:0] p;
   } exp_t;

   exp_t exp_iss [$];
   exp_t exp_res [$];

   int cyc = 0;
   int t0 = 0;
   int exp_done = 0;
   int done_cnt = 0;
   int done_rel = -1;
   bit frame_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         int rel;
         exp_t e;
         rel = cyc - t0;
         if (pcal_sta) begin
            if (exp_iss.size() == 0) chk("iss_extra", 32'd1, 32'd0);
            else begin
               e = exp_iss.pop_front();
               chk("iss_cyc", rel, e.cyc);
               chk("iss_ch", 32'(ch_sel), e.ch);
               $display("issue  rel=%0d ch=%0d", rel, ch_sel);
            end
         end
         if (p_valid) begin
            if (exp_res.size() == 0) chk("res_extra", 32'd1, 32'd0);
            else begin
               e = exp_res.pop_front();
               chk("res_cyc", rel, e.cyc);
               chk("res_ch", 32'(p_ch), e.ch);
               chk("res_p", p_out, e.p);
               $display("result rel=%0d ch=%0d p=%08h", rel, p_ch, p_out);
            end
         end
         if (done_sig) begin
            done_cnt++;
            done_rel = rel;
            $display("done   rel=%0d", rel);
         end
         if (frame_on && rel >= 0 && rel <= exp_done + 1)
            chk("busy", 32'(busy), 32'((rel >= 1) && (rel <= exp_done)));
      end
   end

   task automatic start_frame(input logic [NCH-1:0] mask);
      int n;
      exp_t e;
      @(posedge clk); #1;
      sta      = 1'b1;
      ch_mask  = mask;
      t0       = cyc;
      n        = 0;
      for (int i = 0; i < NCH; i++) begin
         if (mask[i]) begin
            e.cyc = n + 1; e.ch = i; e.p = '0;
            exp_iss.push_back(e);
            e.cyc = n + L + 2; e.p = fval(i + 1);
            exp_res.push_back(e);
            n++;
         end
      end
      exp_done = (n == 0) ? 2 : n + L + 2;
      done_cnt = 0;
      done_rel = -1;
      frame_on = 1'b1;
   endtask

   task automatic wait_frame(input int ghost);
      bit fin = 1'b0;
      for (int c = 1; c <= 200 && !fin; c++) begin
         @(posedge clk); #1;
         sta     = (c == ghost);
         ch_mask = (c == ghost) ? 4'h1 : 4'h0;
         if (done_cnt != 0 && c >= exp_done + 3) fin = 1'b1;
      end
      if (!fin) chk("done_timeout", 32'd0, 32'd1);
      chk("done_cnt", done_cnt, 32'd1);
      chk("done_cyc", done_rel, exp_done);
      chk("iss_left", exp_iss.size(), 32'd0);
      chk("res_left", exp_res.size(), 32'd0);
      frame_on = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ch_sel"}, 32'(ch_sel), 32'd0);
      chk({tag, "_pcal_sta"}, 32'(pcal_sta), 32'd0);
      chk({tag, "_p_out"}, p_out, 32'd0);
      chk({tag, "_p_ch"}, 32'(p_ch), 32'd0);
      chk({tag, "_p_valid"}, 32'(p_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done_sig), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
   endtask

   initial begin
      #1;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      start_frame(4'hF);  wait_frame(0);
      start_frame(4'hA);  wait_frame(0);
      start_frame(4'h0);  wait_frame(0);
      start_frame(4'hF);  wait_frame(10);

      // Spurious result strobe with nothing outstanding
      chk("overrun_pre", 32'(overrun), 32'd0);
      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      chk("overrun_set", 32'(overrun), 32'd1);
      repeat (5) @(posedge clk);
      #1 chk("overrun_hold", 32'(overrun), 32'd1);
      start_frame(4'h5);  wait_frame(0);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // Abort a frame with reset in its cycle 3
      start_frame(4'hF);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      sta = 1'b0;
      ch_mask = '0;
      #1 check_outputs_zero("midrst");
      exp_iss.delete();
      exp_res.delete();
      frame_on = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      done_cnt = 0;
      repeat (40) @(posedge clk);
      #1 chk("post_rst_done", done_cnt, 32'd0);
      start_frame(4'h3);  wait_frame(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/p_cal_scheduler.md
# p_cal_scheduler

Frame sequencer for the shared pipelined floating-point active-power unit (three multipliers plus two adders, fixed latency, `sta`/`done_sig` strobes). The block time-multiplexes one power unit across NCH measurement channels, e.g. several turbine terminals. On a frame start it issues one operand set per cycle for every enabled channel, driving the operand-mux select and the unit's `sta`. It tags each result with its channel, presents the result, and signals frame completion.

## Interface
- NCH, 4, number of channels (2..16)
- CH_W, 2, channel index width, ≥ clog2(NCH)
- TAG_DEPTH, 32, tag FIFO depth; power of two, ≥ unit latency + 1
- WIDTH, 32, `SINGLE` float width
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- sta  in  1  frame start pulse; sampled only in IDLE
- ch_mask  in  NCH  channels to process this frame; latched with sta
- ch_sel  out  CH_W  operand mux select; valid while pcal_sta=1
- pcal_sta  out  1  start strobe to the power unit, one cycle per operand set
- pcal_done  in  1  result strobe from the power unit
- pcal_p  in  WIDTH  power result, valid with pcal_done
- p_out  out  WIDTH  registered result
- p_ch  out  CH_W  channel of p_out
- p_valid  out  1  one-cycle strobe for p_out/p_ch
- busy  out  1  high in ISSUE or DRAIN
- done_sig  out  1  one-cycle frame-complete pulse
- overrun  out  1  sticky: pcal_done arrived with the tag FIFO empty

## Operation
- Reset value of all outputs is 0. State is IDLE, the FIFO is empty, and outstanding=0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - sta=1 latches ch_mask into pending.
  - If pending≠0, next state is ISSUE. If pending=0, next state is DRAIN.
  - sta outside IDLE is ignored. ch_mask bits ≥ NCH do not exist.
- ISSUE: each cycle, select the lowest-index set bit of pending.
  - Registered outputs: ch_sel=index, pcal_sta=1.
  - Clear that bit, push the index into the tag FIFO, and increment outstanding.
  - After the cycle that clears the last bit, next state is DRAIN.
  - If outstanding=TAG_DEPTH, stall: pcal_sta=0 and pending is unchanged.
- Result path, active in any state:
  - pcal_done=1 with FIFO non-empty: pop the tag and decrement outstanding. Next cycle, p_out=pcal_p, p_ch=tag, p_valid=1.
  - pcal_done=1 with FIFO empty: set overrun, no pop, no p_valid.
  - A push and a pop in the same cycle are both performed; outstanding is unchanged.
- DRAIN: when outstanding=0 and no p_valid is still owed, the next cycle gives done_sig=1 and state IDLE.
- The FIFO read and write pointers wrap modulo TAG_DEPTH. Width is clog2(TAG_DEPTH), plus one bit for the count.
- pcal_sta=0 outside ISSUE. ch_sel holds its last value when idle.
- p_out and p_ch hold their value between strobes.
- rst mid-frame aborts immediately:
  - pending, the FIFO, and outstanding are cleared, and all outputs go to 0.
  - The power unit shares rst, so no stale pcal_done follows.
- overrun clears only on rst.

## Timing
- Cycle 0: sta is sampled.
- Cycle 1: first pcal_sta/ch_sel.
- Channels issue back-to-back, one per cycle, in ascending index order.
- With unit latency L, the result for an issue in cycle k arrives as pcal_done at k+L. It appears as p_valid at k+L+1.
- done_sig comes one cycle after the last p_valid.
  - Example: NCH=4, mask=4'hF, L=19.
  - Issues occur in cycles 1–4, with pcal_done in cycles 20–23.
  - p_valid occurs in cycles 21–24, and done_sig in cycle 25.
- Empty mask: DRAIN in cycle 1, done_sig in cycle 2.
- busy is high from cycle 1 through the done_sig cycle inclusive. IDLE is entered after that, so a new sta is accepted from the done_sig cycle+1.
- Result ordering is FIFO. The power unit is in-order, so p_ch follows issue order.

## Test plan
- Full frame: NCH=4, mask=4'hF, a unit model with L=19 returning P=ch+1.0.
  - Required: pcal_sta in cycles 1–4 with ch_sel 0,1,2,3.
  - Required: p_valid in cycles 21–24 with p_ch 0..3 and p_out 1.0..4.0.
  - Required: done_sig in cycle 25.
- Sparse mask 4'b1010: issues ch 1 in cycle 1 and ch 3 in cycle 2; p_valid in cycles 21 and 22; done_sig in cycle 23.
- Empty mask 4'h0: no pcal_sta, no p_valid, done_sig in cycle 2, busy high only in cycles 1–2.
- sta during busy: a second sta in cycle 10 with mask 4'h1 is ignored. The frame completes unchanged and exactly one done_sig is produced.
- Spurious pcal_done in IDLE: overrun=1 next cycle and stays set. No p_valid is produced. A following frame still completes correctly.
- Reset at cycle 3 of a 4'hF frame:
  - All outputs are 0 during rst.
  - After release: no p_valid or done_sig.
  - After release: a new sta with 4'h3 runs normally, with done_sig in cycle 23 relative to the new sta.
